diff_accum: RTL and testbench
=============================

# diff_accum

Windowed averager placed directly downstream of the TDC pair-difference stage. It consumes the stream of signed 20-bit difference samples and accumulates 2^LOG2_N of them. Each completed window produces one rounded mean, held in an output register with a valid/ready handshake toward the readout/UART packer. This reduces TDC noise and readout bandwidth; overruns are flagged, never silently merged.

## Interface
- DATA_W, 20, sample and result width, two's complement
- LOG2_N, 4, log2 of window length N (1..8)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_W  signed difference sample
- in_dval  in  1  sample qualifier; each high cycle is one sample
- clr  in  1  synchronous window restart; clears overrun
- avg_data  out  DATA_W  rounded window mean, signed
- avg_valid  out  1  avg_data holds an unconsumed result
- avg_ready  in  1  consumer accepts result when high with avg_valid
- min_data  out  DATA_W  window minimum (macro-gated, else 0)
- max_data  out  DATA_W  window maximum (macro-gated, else 0)
- sample_cnt  out  LOG2_N  samples accumulated in current window
- overrun  out  1  sticky: a completed window was dropped

## Operation
- Accumulator width DATA_W+LOG2_N, signed; cannot overflow.
- Each in_dval cycle: acc += sign-extended in_data, sample_cnt++.
- Window completes on the sample where sample_cnt == N-1. The final sum includes that sample. Result = (sum + 2^(LOG2_N-1)) >>> LOG2_N (round half toward +inf), truncated to DATA_W (always fits). The accumulator reloads to 0 and sample_cnt to 0 in the same cycle.
- Output FSM, two states:
  - EMPTY: a completion loads avg_data and goes to FULL.
  - FULL: avg_valid&&avg_ready with no completion goes to EMPTY. A completion in the same cycle as avg_valid&&avg_ready loads the new result and stays FULL. A completion with avg_ready low drops the result, sets overrun and stays FULL; the held result is unchanged.
- clr: acc, sample_cnt and min/max trackers reset, and overrun clears. Output register and FSM are unaffected. clr coincident with in_dval discards that sample. clr coincident with a completion cancels the completion.
- Reset: acc=0, sample_cnt=0, avg_data=0, avg_valid=0, overrun=0, min_data=0, max_data=0, FSM=EMPTY. Reset mid-window discards the partial window.

## Timing
- Latency: avg_valid rises the cycle after the clock edge sampling the N-th in_dval.
- Back-to-back samples every cycle are supported without loss while the consumer keeps avg_ready high.
- avg_data, min_data and max_data stay stable while avg_valid is high and avg_ready is low.
- sample_cnt and overrun are registered and update one cycle after the causing event.

## Configuration
- DIFF_ACCUM_MINMAX_EN defined: signed running min/max tracked per window. They load from the first sample and are updated by comparison on each later sample. They are latched into min_data/max_data together with avg_data.
- Not defined: no tracker logic; min_data/max_data tied to 0. Port list is identical either way.

## Structure
- Package diff_accum_pkg holds:
  - DATA_W default constant
  - typedef sample_t (signed [DATA_W-1:0])
  - out-state enum {EMPTY, FULL}
  - rounding-helper function
- One sub-module, diff_accum_minmax: min/max tracker with start/update/clear inputs. It is instantiated only under DIFF_ACCUM_MINMAX_EN.

## Test plan
Parameters: LOG2_N=2 (N=4), DATA_W=20, avg_ready=1 unless stated.
- Positive rounding: samples 1,2,3,4 on consecutive cycles -> avg_data=3 one cycle after sample 4; min=1, max=4 with macro.
- Negative rounding: -1,-2,-3,-4 -> avg_data=-2 (0xFFFFE).
- Width extremes: four samples of 0x7FFFF -> 0x7FFFF. Four samples of 0x80000 -> 0x80000. No wrap in either case.
- Backpressure and overrun: avg_ready=0, two full windows (1,1,1,1 then 9,9,9,9):
  - avg_data stays 1 and overrun=1.
  - With avg_ready=1 and a third window 5,5,5,5 completing in the acceptance cycle, avg_data becomes 5 and stays valid.
- clr: 2 samples, then clr together with a third sample, then 4,4,4,4 -> avg_data=4 and sample_cnt restarts from 0.
- Reset mid-window: 3 samples of 7, then rst for 1 cycle, then 2,2,2,2 -> all outputs 0 during reset, then avg_data=2.

Source files
------------

// File: rtl/diff_accum_pkg.sv
// diff_accum_pkg: shared types, defaults and the rounding helper for diff_accum.
package diff_accum_pkg;

    localparam int DATA_W_DEFAULT = 20;
    localparam int RND_W = 64;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic {EMPTY, FULL} out_state_e;

    // Adds half an LSB of the result, then shifts arithmetically: ties round toward +inf.
    function automatic logic signed [RND_W-1:0] round_mean(
        input logic signed [RND_W-1:0] sum,
        input int                      log2_n
    );
        logic signed [RND_W-1:0] bias;
        bias = 64'sd1 <<< (log2_n - 1);
        return (sum + bias) >>> log2_n;
    endfunction

endpackage

// File: rtl/diff_accum_minmax.sv
// diff_accum_minmax: per-window signed min/max tracker; *_nxt include the current sample.
module diff_accum_minmax
    import diff_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] min_nxt,
    output logic signed [DATA_W-1:0] max_nxt
);

    logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_nxt = update ? ((start || din < min_q) ? din : min_q) : min_q;
        max_nxt = update ? ((start || din > max_q) ? din : max_q) : max_q;
        min_d   = clear ? '0 : min_nxt;
        max_d   = clear ? '0 : max_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/diff_accum.sv
// diff_accum: windowed rounded mean of signed samples with valid/ready output; DIFF_ACCUM_MINMAX_EN adds min/max.
module diff_accum
    import diff_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LOG2_N = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_dval,
    input  logic                     clr,
    output logic signed [DATA_W-1:0] avg_data,
    output logic                     avg_valid,
    input  logic                     avg_ready,
    output logic signed [DATA_W-1:0] min_data,
    output logic signed [DATA_W-1:0] max_data,
    output logic [LOG2_N-1:0]        sample_cnt,
    output logic                     overrun
);

    localparam int ACC_W = DATA_W + LOG2_N;

    logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [LOG2_N-1:0]        cnt_q, cnt_d;
    logic signed [DATA_W-1:0] avg_q, avg_d, mean;
    out_state_e               st_q, st_d;
    logic                     ovr_q, ovr_d;
    logic                     take, done, load;

    always_comb begin
        take  = in_dval && !clr;
        done  = take && (&cnt_q);
        load  = done && (st_q == EMPTY || avg_ready);
        sum   = acc_q + ACC_W'(in_data);
        mean  = DATA_W'(round_mean(RND_W'(sum), LOG2_N));
        acc_d = clr ? '0 : take ? (done ? '0 : sum) : acc_q;
        cnt_d = clr ? '0 : take ? cnt_q + LOG2_N'(1) : cnt_q;
        avg_d = load ? mean : avg_q;
        // A completion while a result is still held and not being taken is dropped.
        st_d  = load ? FULL : (st_q == FULL && avg_ready) ? EMPTY : st_q;
        ovr_d = clr ? 1'b0 : ovr_q | (done && st_q == FULL && !avg_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            st_q  <= EMPTY;
            ovr_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            st_q  <= st_d;
            ovr_q <= ovr_d;
        end
    end

    assign avg_data   = avg_q;
    assign avg_valid  = (st_q == FULL);
    assign sample_cnt = cnt_q;
    assign overrun    = ovr_q;

`ifdef DIFF_ACCUM_MINMAX_EN
    logic signed [DATA_W-1:0] min_nxt, max_nxt, min_q, min_d, max_q, max_d;

    diff_accum_minmax #(.DATA_W(DATA_W)) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (clr),
        .start   (take && cnt_q == '0),
        .update  (take),
        .din     (in_data),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt)
    );

    always_comb begin
        min_d = load ? min_nxt : min_q;
        max_d = load ? max_nxt : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_data = min_q;
    assign max_data = max_q;
`else
    assign min_data = '0;
    assign max_data = '0;
`endif

endmodule

// File: tb/tb_diff_accum.sv
// tb_diff_accum: directed self-checking bench for diff_accum with N=4.
module tb_diff_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] in_data = '0;
    logic        in_dval = 1'b0;
    logic        clr = 1'b0;
    logic        avg_ready = 1'b1;
    logic [19:0] avg_data, min_data, max_data;
    logic        avg_valid, overrun;
    logic [1:0]  sample_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    diff_accum #(.DATA_W(20), .LOG2_N(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_dval    (in_dval),
        .clr        (clr),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .min_data   (min_data),
        .max_data   (max_data),
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mm(input string tag, input logic [19:0] mn, input logic [19:0] mx);
`ifdef DIFF_ACCUM_MINMAX_EN
        chk({tag, "_min"}, {12'b0, min_data}, {12'b0, mn});
        chk({tag, "_max"}, {12'b0, max_data}, {12'b0, mx});
`else
        chk({tag, "_min"}, {12'b0, min_data}, 32'h0);
        chk({tag, "_max"}, {12'b0, max_data}, 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_data = 20'(v);
        in_dval = 1'b1;
        tick();
        in_dval = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_avg", {12'b0, avg_data}, 32'h0);
        chk("rst_valid", {31'b0, avg_valid}, 32'h0);
        chk("rst_ovr", {31'b0, overrun}, 32'h0);
        chk("rst_cnt", {30'b0, sample_cnt}, 32'h0);
        chk_mm("rst", 20'h0, 20'h0);
        rst = 1'b0;
        tick();

        send(1); send(2); send(3);
        chk("pos_cnt3", {30'b0, sample_cnt}, 32'd3);
        chk("pos_valid_early", {31'b0, avg_valid}, 32'h0);
        send(4);
        chk("pos_valid", {31'b0, avg_valid}, 32'h1);
        chk("pos_avg", {12'b0, avg_data}, 32'd3);
        chk("pos_cnt0", {30'b0, sample_cnt}, 32'd0);
        chk_mm("pos", 20'd1, 20'd4);
        tick();
        chk("pos_taken", {31'b0, avg_valid}, 32'h0);

        send(-1); send(-2); send(-3); send(-4);
        chk("neg_avg", {12'b0, avg_data}, 32'hFFFFE);
        chk_mm("neg", 20'hFFFFC, 20'hFFFFF);

        for (int i = 0; i < 4; i++) send(32'h7FFFF);
        chk("max_avg", {12'b0, avg_data}, 32'h7FFFF);
        for (int i = 0; i < 4; i++) send(32'h80000);
        chk("min_avg", {12'b0, avg_data}, 32'h80000);
        tick();

        avg_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1);
        chk("bp_avg1", {12'b0, avg_data}, 32'd1);
        chk("bp_ovr0", {31'b0, overrun}, 32'h0);
        for (int i = 0; i < 4; i++) send(9);
        chk("bp_held", {12'b0, avg_data}, 32'd1);
        chk("bp_valid", {31'b0, avg_valid}, 32'h1);
        chk("bp_ovr1", {31'b0, overrun}, 32'h1);
        chk_mm("bp", 20'd1, 20'd1);
        send(5); send(5); send(5);
        avg_ready = 1'b1;
        send(5);
        avg_ready = 1'b0;
        chk("bp_avg5", {12'b0, avg_data}, 32'd5);
        chk("bp_valid5", {31'b0, avg_valid}, 32'h1);
        chk("bp_ovr_sticky", {31'b0, overrun}, 32'h1);
        tick();
        chk("bp_stable", {12'b0, avg_data}, 32'd5);
        avg_ready = 1'b1;
        tick();
        chk("bp_drain", {31'b0, avg_valid}, 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovr", {31'b0, overrun}, 32'h0);

        send(8); send(8);
        chk("clr_cnt2", {30'b0, sample_cnt}, 32'd2);
        clr = 1'b1;
        send(100);
        clr = 1'b0;
        chk("clr_cnt0", {30'b0, sample_cnt}, 32'd0);
        send(4);
        chk("clr_cnt1", {30'b0, sample_cnt}, 32'd1);
        send(4); send(4); send(4);
        chk("clr_avg", {12'b0, avg_data}, 32'd4);
        chk("clr_valid", {31'b0, avg_valid}, 32'h1);
        chk_mm("clr", 20'd4, 20'd4);

        send(7); send(7); send(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_avg", {12'b0, avg_data}, 32'h0);
        chk("mrst_valid", {31'b0, avg_valid}, 32'h0);
        chk("mrst_cnt", {30'b0, sample_cnt}, 32'h0);
        chk_mm("mrst", 20'h0, 20'h0);
        for (int i = 0; i < 4; i++) send(2);
        chk("mrst_avg2", {12'b0, avg_data}, 32'd2);
        chk("mrst_valid2", {31'b0, avg_valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
